// File: rtl/typer_sequencer.sv
// Multi-cycle R-type sequencer: fetch over req/ack, decode, exec, writeback.
// Optional busy-cycle counter enabled by defining TYPER_SEQ_CYCLE_CNT_EN.
module typer_sequencer #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr_out,
   output logic              br_we,
   output logic [2:0]        alu_ctrl,
   output logic              mem_we,
   output logic              mem_re,
   output logic              wb_sel,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [CNT_W-1:0]  instr_count,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] HALT   = 3'd5;

   logic [2:0]        state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [31:0]       ir_reg;
   logic [2:0]        alu_reg;
   logic              done_reg;
   logic              illegal_reg;
   logic [CNT_W-1:0]  icnt_reg;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       dec_legal;
   logic [2:0] dec_alu;

   assign opcode = ir_reg[31:26];
   assign funct  = ir_reg[5:0];

   // Only opcode 0 carries a funct; shamt is never looked at.
   always_comb begin
      dec_legal = 1'b0;
      dec_alu   = 3'b000;
      if (opcode == 6'b000000) begin
         dec_legal = 1'b1;
         case (funct)
            6'b100000: dec_alu = 3'b010;
            6'b100010: dec_alu = 3'b110;
            6'b100100: dec_alu = 3'b000;
            6'b100101: dec_alu = 3'b001;
            6'b101010: dec_alu = 3'b111;
            default:   dec_legal = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         pc_reg      <= '0;
         ir_reg      <= '0;
         alu_reg     <= 3'b000;
         done_reg    <= 1'b0;
         illegal_reg <= 1'b0;
         icnt_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) state_reg <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  ir_reg    <= imem_rdata;
                  state_reg <= DECODE;
               end
            end
            DECODE: begin
               if (dec_legal) begin
                  alu_reg   <= dec_alu;
                  state_reg <= EXEC;
               end else begin
                  alu_reg     <= 3'b000;
                  done_reg    <= 1'b1;
                  illegal_reg <= (opcode != 6'b111111);
                  state_reg   <= HALT;
               end
            end
            EXEC: state_reg <= WB;
            WB: begin
               if (icnt_reg != '1) icnt_reg <= icnt_reg + 1'b1;
               pc_reg    <= pc_reg + 1'b1;
               state_reg <= FETCH;
            end
            HALT: begin
               if (start) begin
                  done_reg    <= 1'b0;
                  illegal_reg <= 1'b0;
                  pc_reg      <= '0;
                  state_reg   <= FETCH;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign imem_req    = (state_reg == FETCH);
   assign imem_addr   = pc_reg;
   assign instr_out   = ir_reg;
   // Gated by rst so a write caught in WB never lands during reset.
   assign br_we       = (state_reg == WB) && (ir_reg[15:11] != 5'd0) && !rst;
   assign alu_ctrl    = alu_reg;
   assign mem_we      = 1'b0;
   assign mem_re      = 1'b0;
   assign wb_sel      = 1'b1;
   assign busy        = (state_reg == FETCH) || (state_reg == DECODE) ||
                        (state_reg == EXEC)  || (state_reg == WB);
   assign done        = done_reg;
   assign illegal     = illegal_reg;
   assign instr_count = icnt_reg;

`ifdef TYPER_SEQ_CYCLE_CNT_EN
   logic [CNT_W-1:0] ccnt_reg;

   always_ff @(posedge clk) begin
      if (rst || (state_reg == HALT && start)) begin
         ccnt_reg <= '0;
      end else if (busy && ccnt_reg != '1) begin
         ccnt_reg <= ccnt_reg + 1'b1;
      end
   end

   assign cycle_count = ccnt_reg;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_typer_sequencer.sv
// Randomized bench for typer_sequencer; expectations come from an
// instruction-level model (PC, retired count, busy-cycle tally).
module tb_typer_sequencer;

   localparam int AW = 4;
   localparam int CW = 4;
`ifdef TYPER_SEQ_CYCLE_CNT_EN
   localparam bit CYC_EN = 1'b1;
`else
   localparam bit CYC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic [31:0]   instr_out;
   logic          br_we;
   logic [2:0]    alu_ctrl;
   logic          mem_we;
   logic          mem_re;
   logic          wb_sel;
   logic          busy;
   logic          done;
   logic          illegal;
   logic [CW-1:0] instr_count;
   logic [CW-1:0] cycle_count;

   typer_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_out(instr_out), .br_we(br_we), .alu_ctrl(alu_ctrl),
      .mem_we(mem_we), .mem_re(mem_re), .wb_sel(wb_sel),
      .busy(busy), .done(done), .illegal(illegal),
      .instr_count(instr_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state
   int exp_pc  = 0;
   int exp_cnt = 0;
   int exp_cyc = 0;
   bit model_halted = 1'b0;

   logic [5:0] funct_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
   logic [2:0] alu_tab   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int exp_cycles();
      return CYC_EN ? sat(exp_cyc, (1 << CW) - 1) : 0;
   endfunction

   function automatic int exp_count();
      return sat(exp_cnt, (1 << CW) - 1);
   endfunction

   // 0 = legal R-type, 1 = halt, 2 = illegal
   function automatic int classify(input logic [31:0] ins, output logic [2:0] code);
      code = 3'b000;
      if (ins[31:26] == 6'h3f) return 1;
      if (ins[31:26] != 6'h00) return 2;
      for (int i = 0; i < 5; i++)
         if (funct_tab[i] == ins[5:0]) begin
            code = alu_tab[i];
            return 0;
         end
      return 2;
   endfunction

   function automatic logic [31:0] rand_instr();
      int          k;
      logic [31:0] ins;
      k   = $urandom_range(0, 9);
      ins = $urandom;
      if (k <= 6) begin
         ins[31:26] = 6'h00;
         ins[5:0]   = funct_tab[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) ins[15:11] = 5'd0;
      end else if (k == 7) begin
         ins[31:26] = 6'h00;
      end else if (k == 8) begin
         ins[31:26] = 6'($urandom_range(1, 62));
      end else begin
         ins[31:26] = 6'h3f;
      end
      return ins;
   endfunction

   // Entered and left at a negedge; entry is the first FETCH cycle.
   task automatic exec_one(input logic [31:0] ins, input int w);
      logic [2:0] code;
      int         kind;
      bit         wr;
      kind = classify(ins, code);
      wr   = (ins[15:11] != 5'd0);
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(exp_pc % (1 << AW)));
      chk("fetch_busy", 32'(busy), 32'd1);
      chk("fetch_cyc", 32'(cycle_count), 32'(exp_cycles()));
      for (int i = 0; i < w; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         start      = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         chk("stall_req", 32'(imem_req), 32'd1);
      end
      start      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = ins;
      @(posedge clk); @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exp_cyc += w + 2;
      chk("dec_ir", instr_out, ins);
      chk("dec_req", 32'(imem_req), 32'd0);
      chk("dec_we", 32'(br_we), 32'd0);
      @(posedge clk); @(negedge clk);
      if (kind == 0) begin
         chk("exec_alu", 32'(alu_ctrl), 32'(code));
         chk("exec_we", 32'(br_we), 32'd0);
         chk("exec_ir", instr_out, ins);
         @(posedge clk); @(negedge clk);
         chk("wb_we", 32'(br_we), 32'(wr));
         chk("wb_ir", instr_out, ins);
         chk("wb_mem", {30'd0, mem_we, mem_re}, 32'd0);
         chk("wb_sel", 32'(wb_sel), 32'd1);
         exp_cyc += 2;
         exp_cnt++;
         exp_pc++;
         @(posedge clk); @(negedge clk);
         chk("post_we", 32'(br_we), 32'd0);
         chk("post_cnt", 32'(instr_count), 32'(exp_count()));
         chk("post_addr", 32'(imem_addr), 32'(exp_pc % (1 << AW)));
         model_halted = 1'b0;
      end else begin
         chk("halt_done", 32'(done), 32'd1);
         chk("halt_illegal", 32'(illegal), 32'(kind == 2));
         chk("halt_busy", 32'(busy), 32'd0);
         chk("halt_we", 32'(br_we), 32'd0);
         chk("halt_cnt", 32'(instr_count), 32'(exp_count()));
         chk("halt_cyc", 32'(cycle_count), 32'(exp_cycles()));
         if (kind == 2) chk("halt_alu", 32'(alu_ctrl), 32'd0);
         model_halted = 1'b1;
      end
      $display("instr %h wait %0d kind %0d rd %0d count %0d pc %0d",
               ins, w, kind, ins[15:11], exp_count(), exp_pc % (1 << AW));
   endtask

   task automatic restart();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_pc  = 0;
      exp_cyc = 0;
      model_halted = 1'b0;
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_illegal", 32'(illegal), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_ir"}, instr_out, 32'd0);
      chk({tag, "_we"}, 32'(br_we), 32'd0);
      chk({tag, "_alu"}, 32'(alu_ctrl), 32'd0);
      chk({tag, "_flags"}, {27'd0, mem_we, mem_re, busy, done, illegal}, 32'd0);
      chk({tag, "_wbsel"}, 32'(wb_sel), 32'd1);
      chk({tag, "_cnt"}, 32'(instr_count), 32'd0);
      chk({tag, "_cyc"}, 32'(cycle_count), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;

      exec_one(32'h00223820, 0);   // ADD $7
      exec_one(32'h00221822, 5);   // SUB $3, stalled
      exec_one(32'h00220020, 0);   // ADD $0: no write, still retires
      exec_one(32'h00222025, 1);   // OR
      exec_one(32'hFC000000, 0);   // HALT
      restart();
      exec_one(32'h00223821, 2);   // bad funct
      restart();
      for (int i = 0; i < 20; i++) exec_one(32'h00223820, 0);  // PC wrap, count saturation

      for (int i = 0; i < 60; i++) begin
         exec_one(rand_instr(), $urandom_range(0, 3));
         if (model_halted) restart();
      end

      // Reset landing on a WB cycle
      imem_ack = 1'b1; imem_rdata = 32'h00223820;
      @(posedge clk); @(negedge clk);
      imem_ack = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_wb_we", 32'(br_we), 32'd0);
      @(posedge clk); @(negedge clk);
      check_reset_state("rst_wb");
      rst = 1'b0;
      exp_pc = 0; exp_cnt = 0; exp_cyc = 0;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exec_one(32'h00223820, 0);
      chk("one_instr_cyc", 32'(cycle_count), CYC_EN ? 32'd4 : 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/typer_sequencer.md
Name: typer_sequencer

Overview:
- Multi-cycle controller that sequences the R-type datapath (register bank, ALU, writeback mux).
- Fetches 32-bit instructions from an instruction memory over a req/ack handshake and latches each into an instruction register that feeds the datapath.
- Decodes opcode/funct into datapath control and issues exactly one register-bank write per legal instruction.
- Sits between instruction memory and the datapath top; replaces the combinational control unit for multi-cycle operation.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; PC wraps modulo 2^ADDR_W.
- CNT_W, 16, width of instr_count and cycle_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch pulse; sampled only in IDLE or HALT.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  word address, equal to PC.
- imem_ack  in  1  read data valid; honoured only while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- instr_out  out  32  instruction register to the datapath (Rs=[25:21], Rt=[20:16], Rd=[15:11]).
- br_we  out  1  register-bank write enable.
- alu_ctrl  out  3  ALU operation.
- mem_we, mem_re  out  1 each  data-memory enables; always 0 (R-type only).
- wb_sel  out  1  writeback mux select; always 1 (ALU result).
- busy  out  1  high in FETCH, DECODE, EXEC, WB.
- done  out  1  sticky; set on halt.
- illegal  out  1  sticky; set on unsupported opcode/funct.
- instr_count  out  CNT_W  retired legal instructions.
- cycle_count  out  CNT_W  see Optional Feature.

Behaviour:
- Reset: state=IDLE, PC=0, IR=0, every output 0 except wb_sel=1; both counters 0.
- The reset action applies on any cycle, including mid-fetch or during WB. A write pending in WB is suppressed in the reset cycle.
- IDLE: on start=1, go to FETCH. PC is left unchanged (0 after reset).
- FETCH: imem_req=1, imem_addr=PC.
  - On imem_ack=1 (ack may arrive in the same cycle as req), IR<=imem_rdata and go to DECODE.
  - With no ack, stay in FETCH for an unbounded time.
- DECODE: one cycle. Register alu_ctrl from IR:
  - Opcode 000000 with funct 100000 (ADD) -> 010.
  - 100010 (SUB) -> 110.
  - 100100 (AND) -> 000.
  - 100101 (OR) -> 001.
  - 101010 (SLT) -> 111.
  - Opcode 111111 -> HALT: done=1, br_we never asserted.
  - Any other opcode/funct -> HALT: illegal=1 and done=1, alu_ctrl held at 000.
- EXEC: one cycle for ALU settling; br_we=0.
- WB: one cycle.
  - br_we=1 only if Rd!=0; a write to $0 is suppressed but the instruction still retires.
  - instr_count++ and PC<=PC+1 (wraps to 0 after 2^ADDR_W-1). Next state is FETCH.
- Latency: 4 cycles per instruction with zero-wait ack. br_we is high at most 1 cycle per instruction.
- instr_out=IR is stable from DECODE through WB.
- The shamt field is ignored.
- instr_count saturates at all-ones.
- HALT: busy=0; done and illegal hold. On start=1: clear done and illegal, PC<=0, go to FETCH. instr_count is not cleared.
- start is ignored while busy.

Optional Feature:
- Macro TYPER_SEQ_CYCLE_CNT_EN.
- When defined: cycle_count increments on every cycle busy=1, saturates at all-ones, and clears on reset or on a start from HALT.
- When undefined: cycle_count is tied to 0 and no counter flops are built.

Test Plan:
- Reset, start, zero-wait ack, IR data 0x00223820 (ADD $7,$1,$2) -> IR=0x00223820, alu_ctrl=010 from EXEC, br_we=1 exactly in the 4th cycle after fetch, instr_count=1, imem_addr=1.
- Fetch stalled 5 cycles before ack, IR data 0x00221822 (SUB $3,$1,$2) -> imem_req held 6 cycles, alu_ctrl=110, single br_we pulse, no duplicate write.
- IR data 0x00220020 (ADD $0,$1,$2) -> br_we stays 0, instr_count increments, PC advances.
- Sequence ADD, OR (0x00222025), then 0xFC000000 -> alu_ctrl 010 then 001, done=1, busy=0, instr_count=2. A later start clears done and refetches from address 0.
- IR data 0x00223821 (bad funct) -> illegal=1, done=1, no br_we. ADDR_W=2 with 4 ADDs -> PC wraps 3->0.
- rst asserted in WB -> no br_we that cycle, all outputs 0 next cycle. With the macro defined, cycle_count=4 after one zero-wait instruction.
